// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
// Optional macro OVERFLOW_FLAG_EN adds a two's-complement signed-overflow output.
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_in_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_out_o,
  output logic             busy_o
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT:0]   dsum;
  int               dig_pos;

`ifdef OVERFLOW_FLAG_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef OVERFLOW_FLAG_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    dig_pos = int'(cnt_q) * DIGIT;
`ifdef OVERFLOW_FLAG_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    // one digit of the sum plus its carry, at DIGIT+1 bits
    dsum = {1'b0, a_sh_q[DIGIT-1:0]} + {1'b0, b_sh_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

    case (state_q)
      S_IDLE: begin
`ifdef OVERFLOW_FLAG_EN
        ovf_d = 1'b0;
`endif
        if (in_valid_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          carry_d = carry_in_i;
          cnt_d   = '0;
          state_d = S_RUN;
`ifdef OVERFLOW_FLAG_EN
          a_msb_d = a_i[WIDTH-1];
          b_msb_d = b_i[WIDTH-1];
`endif
        end
      end
      S_RUN: begin
        sum_d[dig_pos +: DIGIT] = dsum[DIGIT-1:0];
        carry_d = dsum[DIGIT];
        a_sh_d  = a_sh_q >> DIGIT;
        b_sh_d  = b_sh_q >> DIGIT;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(NDIG - 1)) begin
          state_d = S_DONE;
          cout_d  = dsum[DIGIT];
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = (a_msb_q == b_msb_q) && (sum_d[WIDTH-1] != a_msb_q);
`endif
        end
      end
      S_DONE: begin
        if (out_ready_i) begin
          state_d = S_IDLE;
`ifdef OVERFLOW_FLAG_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign sum_o       = sum_q;
  assign carry_out_o = cout_q;
`ifdef OVERFLOW_FLAG_EN
  assign overflow_o  = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed and randomised checks of digit_serial_adder at DIGIT=4 (main), DIGIT=16 and DIGIT=1.
// Build with OVERFLOW_FLAG_EN defined to also exercise the overflow output.
module tb_digit_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a, b;
  logic        cin;

  logic        rdy4, rdy16, rdy1;
  logic        ov4, ov16, ov1;
  logic [15:0] sum4, sum16, sum1;
  logic        co4, co16, co1;
  logic        busy4, busy16, busy1;
`ifdef OVERFLOW_FLAG_EN
  logic        ovf4, ovf16, ovf1;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy4),
    .a_i(a), .b_i(b), .carry_in_i(cin), .out_valid_o(ov4), .out_ready_i(out_ready),
    .sum_o(sum4), .carry_out_o(co4), .busy_o(busy4)
`ifdef OVERFLOW_FLAG_EN
    , .overflow_o(ovf4)
`endif
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(16)) u_d16 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy16),
    .a_i(a), .b_i(b), .carry_in_i(cin), .out_valid_o(ov16), .out_ready_i(out_ready),
    .sum_o(sum16), .carry_out_o(co16), .busy_o(busy16)
`ifdef OVERFLOW_FLAG_EN
    , .overflow_o(ovf16)
`endif
  );

  digit_serial_adder #(.WIDTH(16), .DIGIT(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .a_i(a), .b_i(b), .carry_in_i(cin), .out_valid_o(ov1), .out_ready_i(out_ready),
    .sum_o(sum1), .carry_out_o(co1), .busy_o(busy1)
`ifdef OVERFLOW_FLAG_EN
    , .overflow_o(ovf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic cv);
    a        = av;
    b        = bv;
    cin      = cv;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [15:0] exp_a [4] = '{16'h0001, 16'h8000, 16'hABCD, 16'h00FF};
  logic [15:0] exp_b [4] = '{16'h0002, 16'h8000, 16'h1111, 16'h0F01};
  logic [16:0] gold;
  int          n_acc, n_res, last_acc, cyc;
  bit          saw, s4, s16, s1;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(rdy4), 32'd1);
    chk("rst_out_valid", 32'(ov4), 32'd0);
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_sum", 32'(sum4), 32'h0);
    chk("rst_cout", 32'(co4), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("rst_ovf", 32'(ovf4), 32'd0);
`endif
    rst = 1'b0;

    // FFFF + 0001: result after exactly 4 clocks, then held 10 cycles with out_ready low
    start_op(16'hFFFF, 16'h0001, 1'b0);
    chk("t1_busy", 32'(busy4), 32'd1);
    chk("t1_in_ready", 32'(rdy4), 32'd0);
    tick(); tick(); tick();
    chk("t1_not_early", 32'(ov4), 32'd0);
    tick();
    chk("t1_valid", 32'(ov4), 32'd1);
    chk("t1_sum", 32'(sum4), 32'h0000);
    chk("t1_cout", 32'(co4), 32'd1);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      chk("t3_hold_valid", 32'(ov4), 32'd1);
      chk("t3_hold_sum", 32'(sum4), 32'h0000);
      chk("t3_hold_cout", 32'(co4), 32'd1);
      chk("t3_in_ready", 32'(rdy4), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("t3_release_valid", 32'(ov4), 32'd0);
    chk("t3_release_ready", 32'(rdy4), 32'd1);
    chk("t3_release_busy", 32'(busy4), 32'd0);

    // 1234 + 4321 + 1
    start_op(16'h1234, 16'h4321, 1'b1);
    tick(); tick(); tick(); tick();
    chk("t2_valid", 32'(ov4), 32'd1);
    chk("t2_sum", 32'(sum4), 32'h5556);
    chk("t2_cout", 32'(co4), 32'd0);
`ifdef OVERFLOW_FLAG_EN
    chk("t2_ovf", 32'(ovf4), 32'd0);
`endif
    tick();
    chk("t2_idle", 32'(rdy4), 32'd1);
`ifdef OVERFLOW_FLAG_EN
    start_op(16'h7FFF, 16'h0001, 1'b0);
    tick(); tick(); tick(); tick();
    chk("ovf_sum", 32'(sum4), 32'h8000);
    chk("ovf_flag", 32'(ovf4), 32'd1);
    chk("ovf_cout", 32'(co4), 32'd0);
    tick();
    chk("ovf_clear", 32'(ovf4), 32'd0);
`endif

    // reset during RUN at cnt=2 discards the operation
    start_op(16'h1111, 16'h2222, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_in_ready", 32'(rdy4), 32'd1);
    chk("t4_out_valid", 32'(ov4), 32'd0);
    chk("t4_busy", 32'(busy4), 32'd0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ov4) saw = 1'b1;
    end
    chk("t4_no_pulse", 32'(saw), 32'd0);
    start_op(16'h0F0F, 16'hF0F1, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t4_valid", 32'(ov4), 32'd1);
    chk("t4_sum", 32'(sum4), 32'h0000);
    chk("t4_cout", 32'(co4), 32'd1);
    tick();

    // back-to-back with in_valid and out_ready high: accept every 6 cycles, in-order results
    rst = 1'b1; tick(); rst = 1'b0;
    n_acc = 0; n_res = 0; last_acc = -1; cyc = 0; cin = 1'b0; in_valid = 1'b1;
    while (n_res < 4 && cyc < 60) begin
      if (ov4) begin
        gold = {1'b0, exp_a[n_res]} + {1'b0, exp_b[n_res]};
        chk("t6_sum", 32'(sum4), 32'(gold[15:0]));
        chk("t6_cout", 32'(co4), 32'(gold[16]));
        n_res++;
      end
      if (rdy4 && n_acc < 4) begin
        a = exp_a[n_acc];
        b = exp_b[n_acc];
        if (last_acc >= 0) chk("t6_interval", 32'(cyc - last_acc), 32'd6);
        last_acc = cyc;
        n_acc++;
      end else if (n_acc == 4) begin
        in_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    chk("t6_results_seen", 32'(n_res), 32'd4);

    // random ops on all three digit widths against a golden adder
    rst = 1'b1; tick(); rst = 1'b0;
    for (int op = 0; op < 1000; op++) begin
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom_range(0, 1));
      gold = {1'b0, a} + {1'b0, b} + {16'h0, cin};
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      s4 = 1'b0; s16 = 1'b0; s1 = 1'b0;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (ov16 && !s16) begin
          s16 = 1'b1;
          chk("t5_lat16", 32'(t), 32'd1);
          chk("t5_sum16", 32'(sum16), 32'(gold[15:0]));
          chk("t5_cout16", 32'(co16), 32'(gold[16]));
        end
        if (ov4 && !s4) begin
          s4 = 1'b1;
          chk("t5_lat4", 32'(t), 32'd4);
          chk("t5_sum4", 32'(sum4), 32'(gold[15:0]));
          chk("t5_cout4", 32'(co4), 32'(gold[16]));
        end
        if (ov1 && !s1) begin
          s1 = 1'b1;
          chk("t5_lat1", 32'(t), 32'd16);
          chk("t5_sum1", 32'(sum1), 32'(gold[15:0]));
          chk("t5_cout1", 32'(co1), 32'(gold[16]));
        end
        if (s4 && s16 && s1) break;
      end
      chk("t5_all_done", 32'({s4, s16, s1}), 32'b111);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
